// File: rtl/sr04_pkg.sv
// Shared types and widths for the SR04 distance-to-BCD stage.
package sr04_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

   localparam int BCD_DIGITS = 4;
   localparam int CONV_W     = 14;
   localparam int DIST_W     = 24;
   localparam int SR_W       = BCD_DIGITS * 4 + CONV_W;

   // Full-width compare so large garbage readings clamp high instead of wrapping.
   function automatic logic [CONV_W-1:0] clamp_cm(input logic [DIST_W-1:0] raw,
                                                  input int lo, input int hi);
      if (raw < DIST_W'(lo))
         return CONV_W'(lo);
      else if (raw > DIST_W'(hi))
         return CONV_W'(hi);
      else
         return raw[CONV_W-1:0];
   endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble iteration: add 3 to each BCD nibble >= 5, then shift left by one.
module bin2bcd_step
   import sr04_pkg::*;
(
   input  logic [SR_W-1:0] din,
   output logic [SR_W-1:0] dout
);

   logic [SR_W-1:0] adj;

   always_comb begin
      adj = din;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         if (din[CONV_W + 4*d +: 4] >= 4'd5)
            adj[CONV_W + 4*d +: 4] = din[CONV_W + 4*d +: 4] + 4'd3;
      end
      dout = SR_W'({adj, 1'b0});
   end

endmodule

// File: rtl/sr04_dist_bcd.sv
// Clamps the SR04 distance and converts it to 4-digit packed BCD.
// Define SR04_AVG4_EN to convert the mean of the last 4 clamped samples instead.
module sr04_dist_bcd
   import sr04_pkg::*;
#(
   parameter int MIN_CM = 2,
   parameter int MAX_CM = 400
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DIST_W-1:0] i_distance,
   output logic [15:0]       o_bcd,
   output logic              o_valid,
   output logic              o_oor,
   output logic              o_busy
);

   localparam int SAMP_W = $clog2(MAX_CM + 1);
   localparam int SUM_W  = SAMP_W + 2;

   state_t            state;
   logic [DIST_W-1:0] last_raw;
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   sr_step;
   logic [3:0]        iter;
   logic              pend_oor;
   logic              raw_oor;
   logic [CONV_W-1:0] load_val;

   assign raw_oor = (last_raw < DIST_W'(MIN_CM)) || (last_raw > DIST_W'(MAX_CM));

`ifdef SR04_AVG4_EN
   logic [SAMP_W-1:0] avg_buf [4];
   logic              avg_primed;
   logic [SAMP_W-1:0] sample;
   logic [SUM_W-1:0]  avg_sum;

   assign sample   = SAMP_W'(clamp_cm(i_distance, MIN_CM, MAX_CM));
   assign avg_sum  = SUM_W'(avg_buf[0]) + SUM_W'(avg_buf[1])
                   + SUM_W'(avg_buf[2]) + SUM_W'(avg_buf[3]);
   assign load_val = CONV_W'(avg_sum >> 2);
`else
   assign load_val = clamp_cm(last_raw, MIN_CM, MAX_CM);
`endif

   bin2bcd_step u_step (
      .din  (sr),
      .dout (sr_step)
   );

   // o_valid is a one-cycle strobe with no back-pressure: o_bcd/o_oor change only
   // on the cycle o_valid is high and hold until the next strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         last_raw <= '0;
         sr       <= '0;
         iter     <= '0;
         pend_oor <= 1'b0;
         o_bcd    <= '0;
         o_valid  <= 1'b0;
         o_oor    <= 1'b0;
         o_busy   <= 1'b0;
`ifdef SR04_AVG4_EN
         avg_primed <= 1'b0;
         for (int i = 0; i < 4; i++) avg_buf[i] <= '0;
`endif
      end else begin
         o_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (i_distance != last_raw) begin
                  last_raw <= i_distance;
                  o_busy   <= 1'b1;
                  state    <= LOAD;
`ifdef SR04_AVG4_EN
                  if (!avg_primed) begin
                     for (int i = 0; i < 4; i++) avg_buf[i] <= sample;
                     avg_primed <= 1'b1;
                  end else begin
                     avg_buf[0] <= sample;
                     for (int i = 1; i < 4; i++) avg_buf[i] <= avg_buf[i-1];
                  end
`endif
               end
            end
            LOAD: begin
               pend_oor <= raw_oor;
               sr       <= {{(BCD_DIGITS*4){1'b0}}, load_val};
               iter     <= '0;
               state    <= CONV;
            end
            CONV: begin
               sr <= sr_step;
               if (iter == 4'(CONV_W - 1))
                  state <= DONE;
               else
                  iter <= iter + 4'd1;
            end
            DONE: begin
               o_bcd   <= sr[SR_W-1:CONV_W];
               o_oor   <= pend_oor;
               o_valid <= 1'b1;
               o_busy  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sr04_dist_bcd.md
# sr04_dist_bcd

Downstream stage of the SR04 ultrasonic controller: watches the controller's 24-bit `distance` result, clamps it to the sensor's valid range, and converts it to 4-digit packed BCD with a sequential shift-add-3 (double-dabble) engine. It drives the FND display driver and flags out-of-range readings. Optionally it applies a 4-sample moving average before conversion.

## Interface
- `MIN_CM`, 2, lowest valid distance in cm; smaller values clamp to this.
- `MAX_CM`, 400, highest valid distance in cm; larger values clamp to this. Must be ≤ 9999.
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `i_distance`  in  24  distance in cm from the SR04 controller, held stable between measurements
- `o_bcd`  out  16  packed BCD, `[15:12]` is thousands and `[3:0]` is ones; updated only in DONE
- `o_valid`  out  1  one-cycle pulse when `o_bcd`/`o_oor` update
- `o_oor`  out  1  newest raw sample was < `MIN_CM` or > `MAX_CM`; updated with `o_bcd`
- `o_busy`  out  1  high in LOAD, CONV, DONE

## Operation
- The block runs a 4-state FSM: IDLE, LOAD, CONV, DONE.
- IDLE:
  - Compares `i_distance` against the internal `last_raw` register, which resets to 0.
  - If they differ, capture `i_distance` into `last_raw` and go to LOAD.
  - If they are equal, stay in IDLE.
- LOAD:
  - Clamp the raw value to [`MIN_CM`, `MAX_CM`] using a full 24-bit compare.
  - Compute the pending out-of-range flag from the raw value.
  - Load the 14-bit clamped (or averaged) value into the shift register with the BCD field cleared.
  - Clear the iteration counter, then go to CONV.
- CONV:
  - Each cycle, add 3 to every BCD nibble ≥ 5, then shift the combined 30-bit register left by 1.
  - After exactly 14 iterations (counter 0..13), go to DONE.
- DONE:
  - `o_bcd` ← BCD field.
  - `o_oor` ← pending flag.
  - `o_valid` = 1 for this cycle only.
  - Return to IDLE.
- Changes on `i_distance` outside IDLE are ignored. On return to IDLE the compare against `last_raw` picks up the newest value, so the final settled value is always converted and intermediate values may be dropped.
- Arithmetic: the clamped value fits in 9 bits and is zero-extended to 14 bits. Values up to 9999 convert exactly.

## Timing
- Reset values: state IDLE, `last_raw` 0, `o_bcd` 0, `o_valid` 0, `o_oor` 0, `o_busy` 0, average buffer 0.
- Reset mid-operation returns to the reset state immediately. No `o_valid` is produced for the aborted conversion.
- Latency, with the change first seen at rising edge k in IDLE:
  - Edge k: go to LOAD.
  - Edge k+1: go to CONV.
  - Edges k+2 … k+15: the 14 iterations; edge k+15 enters DONE.
  - Edge k+16: outputs update and `o_valid` rises; it is high until edge k+17.
- Throughput: one conversion per 17 cycles at most.
- `i_distance` = 0 after reset matches `last_raw` and produces no conversion.

## Configuration
- `SR04_AVG4_EN` defined:
  - LOAD converts the truncated mean (sum >> 2) of the last 4 clamped samples, using an 11-bit sum.
  - The first capture after reset fills all 4 entries with that sample.
  - `o_oor` still reflects the newest raw sample only.
- `SR04_AVG4_EN` undefined: the clamped sample is converted directly and no buffer is built.

## Structure
- `sr04_pkg` holds:
  - the state typedef (IDLE/LOAD/CONV/DONE)
  - `BCD_DIGITS` = 4
  - `CONV_W` = 14
  - `DIST_W` = 24
- Sub-module `bin2bcd_step`: one combinational double-dabble iteration (add-3 correction on 4 nibbles plus a 1-bit shift), instantiated once in CONV.
- The FSM, clamp, average buffer and output registers stay in the top module.

## Test plan
- Reset, then `i_distance` 0 → 100 → `o_valid` at edge k+16, `o_bcd` = 16'h0100, `o_oor` = 0, `o_busy` high for 16 cycles.
- `i_distance` = 400 → `o_bcd` 16'h0400 with `o_oor` 0; then 1234 → `o_bcd` 16'h0400 with `o_oor` 1.
- `i_distance` = 1 → `o_bcd` 16'h0002, `o_oor` 1; then 2 → `o_bcd` 16'h0002, `o_oor` 0.
- `i_distance` = 58, then 250 driven 5 cycles later → first `o_valid` with 16'h0058, second `o_valid` 17 cycles later with 16'h0250, no other pulses.
- Start a conversion of 321, assert `rst` during CONV iteration 8 → all outputs 0, no `o_valid`; after release, set 321 again → 16'h0321.
- With `SR04_AVG4_EN`, feed 100, 200, 300, 400 → `o_bcd` sequence 0100, 0125, 0175, 0250.
